// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: FSM state encoding, bus levels and
// the default stuffing run length.
package can_pkg;

  // One-hot state encoding, same style as the downstream sequence detector.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    STUFF = 4'b0100,
    ERR   = 4'b1000
  } state_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // Identical consecutive bits after which a stuff bit is inserted.
  localparam int STUFF_LEN_DEF = 5;

  // True when exactly one bit of a 4-bit one-hot state vector is set.
  function automatic logic is_onehot4(input logic [3:0] s);
    logic [3:0] low;
    low = s - 4'd1;
    return ((s & low) == 4'd0) && (s != 4'd0);
  endfunction

endpackage

// File: rtl/can_bit_destuff_if.sv
// Serial receive interface of the bit destuffer: the sampled bus bit and
// frame-region controls in, the destuffed stream and status out.
interface can_bit_destuff_if #(
  parameter int CNT_W = 8
);

  logic             sample_en;
  logic             rx_bit;
  logic             destuff_en;
  logic             err_clr;
  logic             dout;
  logic             dout_valid;
  logic             stuff_drop;
  logic             stuff_err;
  logic [CNT_W-1:0] bit_cnt;

  // Bit-timing / frame-tracking side that feeds sampled bits in.
  modport master (
    output sample_en, rx_bit, destuff_en, err_clr,
    input  dout, dout_valid, stuff_drop, stuff_err, bit_cnt
  );

  // The destuffer itself.
  modport slave (
    input  sample_en, rx_bit, destuff_en, err_clr,
    output dout, dout_valid, stuff_drop, stuff_err, bit_cnt
  );

endinterface

// File: rtl/can_bit_destuff_chk.sv
// Invariant checker for the bit destuffer; observes internal state only.
module can_bit_destuff_chk
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input logic       clk,
  input logic       rst,
  input state_t     state,
  input logic [2:0] run_cnt,
  input logic       dout_valid,
  input logic       stuff_drop,
  input logic       stuff_err
);

  localparam logic [2:0] RUN_LIMIT = 3'(STUFF_LEN);

  // A removed stuff bit is never also presented as data.
  a_no_valid_and_drop: assert property (@(posedge clk) disable iff (rst)
    !(dout_valid && stuff_drop));

  // State register always holds a legal one-hot code.
  a_state_onehot: assert property (@(posedge clk) disable iff (rst)
    is_onehot4(state));

  // The run counter never passes the stuffing limit.
  a_run_bound: assert property (@(posedge clk) disable iff (rst)
    run_cnt <= RUN_LIMIT);

  // The sticky error flag is high exactly while parked in ERR.
  a_err_matches_state: assert property (@(posedge clk) disable iff (rst)
    (state == ERR) == stuff_err);

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer. Removes stuff bits while the frame is in its
// stuffed region, passes bits straight through otherwise, and flags a stuff
// violation (one identical bit too many) with a sticky error.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  can_bit_destuff_if.slave bus
);

  localparam logic [2:0]       RUN_LIMIT = 3'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nx;
  logic [2:0]       run_cnt_r, run_cnt_nx;
  logic             last_bit_r, last_bit_nx;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nx;
  logic             dout_r, dout_nx;
  logic             dout_valid_r, dout_valid_nx;
  logic             stuff_drop_r, stuff_drop_nx;
  logic             stuff_err_r, stuff_err_nx;

  // Per-edge action selected by the state decode, and the run/count context
  // that a data bit is accumulated onto.
  logic             pass_s;
  logic             proc_run_s;
  logic             proc_stuff_s;
  logic [2:0]       run_base_s;
  logic             last_base_s;
  logic [CNT_W-1:0] cnt_base_s;

  // Emitted-bit counter increments but sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // State and registered outputs; async reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      run_cnt_r    <= 3'd0;
      last_bit_r   <= RECESSIVE;
      bit_cnt_r    <= {CNT_W{1'b0}};
      dout_r       <= RECESSIVE;
      dout_valid_r <= 1'b0;
      stuff_drop_r <= 1'b0;
      stuff_err_r  <= 1'b0;
    end else begin
      state_r      <= state_nx;
      run_cnt_r    <= run_cnt_nx;
      last_bit_r   <= last_bit_nx;
      bit_cnt_r    <= bit_cnt_nx;
      dout_r       <= dout_nx;
      dout_valid_r <= dout_valid_nx;
      stuff_drop_r <= stuff_drop_nx;
      stuff_err_r  <= stuff_err_nx;
    end
  end

  // Next-state decode: err_clr beats region end, which beats the sample.
  always_comb begin
    state_nx      = state_r;
    run_cnt_nx    = run_cnt_r;
    last_bit_nx   = last_bit_r;
    bit_cnt_nx    = bit_cnt_r;
    dout_nx       = dout_r;
    dout_valid_nx = 1'b0;
    stuff_drop_nx = 1'b0;
    stuff_err_nx  = stuff_err_r;
    pass_s        = 1'b0;
    proc_run_s    = 1'b0;
    proc_stuff_s  = 1'b0;
    run_base_s    = run_cnt_r;
    last_base_s   = last_bit_r;
    cnt_base_s    = bit_cnt_r;

    case (state_r)
      ERR: begin
        // Parked until cleared; samples and region changes are ignored.
        if (bus.err_clr) begin
          stuff_err_nx = 1'b0;
          state_nx     = IDLE;
          run_cnt_nx   = 3'd0;
          bit_cnt_nx   = {CNT_W{1'b0}};
          last_bit_nx  = RECESSIVE;
        end else begin
          state_nx = ERR;
        end
      end

      IDLE: begin
        run_cnt_nx  = 3'd0;
        bit_cnt_nx  = {CNT_W{1'b0}};
        last_bit_nx = RECESSIVE;
        if (bus.destuff_en) begin
          // Region opens: this edge's sample already counts as a RUN bit
          // starting from an empty run.
          state_nx    = RUN;
          proc_run_s  = bus.sample_en;
          run_base_s  = 3'd0;
          last_base_s = RECESSIVE;
          cnt_base_s  = {CNT_W{1'b0}};
        end else begin
          pass_s = bus.sample_en;
        end
      end

      RUN, STUFF: begin
        if (!bus.destuff_en) begin
          // Region closed: drop any pending stuff expectation, no error.
          state_nx    = IDLE;
          run_cnt_nx  = 3'd0;
          bit_cnt_nx  = {CNT_W{1'b0}};
          last_bit_nx = RECESSIVE;
          pass_s      = bus.sample_en;
        end else if (state_r == RUN) begin
          proc_run_s = bus.sample_en;
        end else begin
          proc_stuff_s = bus.sample_en;
        end
      end

      default: begin
        state_nx    = IDLE;
        run_cnt_nx  = 3'd0;
        bit_cnt_nx  = {CNT_W{1'b0}};
        last_bit_nx = RECESSIVE;
      end
    endcase

    if (pass_s) begin
      dout_nx       = bus.rx_bit;
      dout_valid_nx = 1'b1;
    end else begin
      dout_valid_nx = dout_valid_nx;
    end

    if (proc_run_s) begin
      // Data bit: emit, count, and extend or restart the identical-bit run.
      dout_nx       = bus.rx_bit;
      dout_valid_nx = 1'b1;
      bit_cnt_nx    = sat_inc(cnt_base_s);
      last_bit_nx   = bus.rx_bit;
      if (bus.rx_bit == last_base_s) begin
        run_cnt_nx = run_base_s + 3'd1;
      end else begin
        run_cnt_nx = 3'd1;
      end
      if (run_cnt_nx == RUN_LIMIT) begin
        state_nx = STUFF;
      end else begin
        state_nx = RUN;
      end
    end else begin
      run_cnt_nx = run_cnt_nx;
    end

    if (proc_stuff_s) begin
      if (bus.rx_bit != last_bit_r) begin
        // Genuine stuff bit: swallow it; it opens the next run.
        stuff_drop_nx = 1'b1;
        last_bit_nx   = bus.rx_bit;
        run_cnt_nx    = 3'd1;
        state_nx      = RUN;
      end else begin
        stuff_err_nx = 1'b1;
        state_nx     = ERR;
      end
    end else begin
      stuff_err_nx = stuff_err_nx;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.stuff_drop = stuff_drop_r;
  assign bus.stuff_err  = stuff_err_r;
  assign bus.bit_cnt    = bit_cnt_r;

  can_bit_destuff_chk #(
    .STUFF_LEN (STUFF_LEN)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .run_cnt    (run_cnt_r),
    .dout_valid (dout_valid_r),
    .stuff_drop (stuff_drop_r),
    .stuff_err  (stuff_err_r)
  );

endmodule

// File: tb/tb_can_bit_destuff.sv
// Self-checking bench for can_bit_destuff: directed scenarios plus a long
// randomized run against a sliding-window destuffing model.
module tb_can_bit_destuff;
  import can_pkg::*;

  localparam int CNT_W = 8;
  localparam int SL    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  can_bit_destuff_if #(.CNT_W(CNT_W)) bus ();

  can_bit_destuff #(.STUFF_LEN(SL), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: region flag, sticky error, last SL bits seen in the
  // stuffed stream (stuff bits included), emitted-bit count.
  bit m_region, m_err, m_dout, e_valid, e_drop;
  bit hist[$];
  int m_cnt;

  task automatic model_reset();
    m_region = 1'b0; m_err = 1'b0; m_dout = 1'b1;
    e_valid = 1'b0; e_drop = 1'b0; hist.delete(); m_cnt = 0;
  endtask

  task automatic push_hist(input bit b);
    hist.push_back(b);
    if (hist.size() > SL) void'(hist.pop_front());
  endtask

  // One clock edge of the model.
  task automatic model_step(input bit se, input bit rx, input bit de, input bit ec);
    bit uniform;
    e_valid = 1'b0; e_drop = 1'b0;
    if (m_err) begin
      if (ec) begin m_err = 1'b0; m_region = 1'b0; hist.delete(); m_cnt = 0; end
    end else if (!de) begin
      m_region = 1'b0; hist.delete(); m_cnt = 0;
      if (se) begin m_dout = rx; e_valid = 1'b1; end
    end else begin
      if (!m_region) begin m_region = 1'b1; hist.delete(); m_cnt = 0; end
      if (se) begin
        uniform = (hist.size() == SL);
        for (int i = 1; i < hist.size(); i++) if (hist[i] != hist[0]) uniform = 1'b0;
        if (uniform) begin
          if (rx != hist[SL-1]) begin e_drop = 1'b1; push_hist(rx); end
          else m_err = 1'b1;
        end else begin
          push_hist(rx); e_valid = 1'b1; m_dout = rx;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
      end
    end
  endtask

  // Drive one cycle at the falling edge; outputs are settled #1 after rise.
  task automatic cycle(input bit se, input bit rx, input bit de, input bit ec);
    @(negedge clk);
    bus.sample_en = se; bus.rx_bit = rx; bus.destuff_en = de; bus.err_clr = ec;
    @(posedge clk);
    model_step(se, rx, de, ec);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_en = 1'b0; bus.rx_bit = 1'b1; bus.destuff_en = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    #12;
    n_total++; if (bus.dout !== 1'b1) $display("FAIL reset_dout got %b want 1", bus.dout); else n_pass++;
    n_total++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.dout_valid); else n_pass++;
    n_total++; if (bus.stuff_drop !== 1'b0) $display("FAIL reset_drop got %b want 0", bus.stuff_drop); else n_pass++;
    n_total++; if (bus.stuff_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.stuff_err); else n_pass++;
    n_total++; if (bus.bit_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", bus.bit_cnt); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_pass_through();
    bit bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      n_total++; if (bus.dout_valid !== 1'b1 || bus.dout !== bits[i])
        $display("FAIL pass_bit%0d got v=%b d=%b want v=1 d=%b", i, bus.dout_valid, bus.dout, bits[i]); else n_pass++;
      n_total++; if (bus.bit_cnt !== 8'd0) $display("FAIL pass_cnt%0d got %0d want 0", i, bus.bit_cnt); else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.dout_valid !== 1'b0) $display("FAIL pass_gap got v=%b want 0", bus.dout_valid); else n_pass++;
  endtask

  task automatic test_stuff_removal();
    bit bits[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit ev[7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, bits[i], 1'b1, 1'b0);
      n_total++; if (bus.dout_valid !== ev[i] || bus.stuff_drop !== !ev[i] || (ev[i] && bus.dout !== bits[i]))
        $display("FAIL stuff_rm%0d got v=%b drop=%b d=%b want v=%b drop=%b d=%b",
                 i, bus.dout_valid, bus.stuff_drop, bus.dout, ev[i], !ev[i], bits[i]); else n_pass++;
    end
    n_total++; if (bus.bit_cnt !== 8'd6) $display("FAIL stuff_rm_cnt got %0d want 6", bus.bit_cnt); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.bit_cnt !== 8'd0) $display("FAIL stuff_rm_cnt_clr got %0d want 0", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_stuff_run();
    bit bits[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    bit dr[11]   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, bits[i], 1'b1, 1'b0);
      n_total++; if (bus.stuff_drop !== dr[i] || bus.dout_valid !== !dr[i] || bus.stuff_err !== 1'b0)
        $display("FAIL stuff_run%0d got drop=%b v=%b err=%b want drop=%b v=%b err=0",
                 i, bus.stuff_drop, bus.dout_valid, bus.stuff_err, dr[i], !dr[i]); else n_pass++;
    end
    n_total++; if (bus.bit_cnt !== 8'd9) $display("FAIL stuff_run_cnt got %0d want 9", bus.bit_cnt); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stuff_error();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      n_total++; if (bus.dout_valid !== (i < 5) || bus.stuff_err !== (i == 5) || bus.stuff_drop !== 1'b0)
        $display("FAIL err_seq%0d got v=%b err=%b drop=%b want v=%b err=%b drop=0",
                 i, bus.dout_valid, bus.stuff_err, bus.stuff_drop, i < 5, i == 5); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i[0], (i != 1), 1'b0);
      n_total++; if (bus.dout_valid !== 1'b0 || bus.stuff_drop !== 1'b0 || bus.stuff_err !== 1'b1)
        $display("FAIL err_hold%0d got v=%b drop=%b err=%b want 0 0 1",
                 i, bus.dout_valid, bus.stuff_drop, bus.stuff_err); else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    n_total++; if (bus.stuff_err !== 1'b0) $display("FAIL err_clr got %b want 0", bus.stuff_err); else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_total++; if (bus.dout_valid !== 1'b1 || bus.dout !== 1'b1 || bus.bit_cnt !== 8'd0)
      $display("FAIL err_idle got v=%b d=%b cnt=%0d want 1 1 0", bus.dout_valid, bus.dout, bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_region_end();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_total++; if (bus.bit_cnt !== 8'd5) $display("FAIL end_cnt5 got %0d want 5", bus.bit_cnt); else n_pass++;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.dout_valid !== 1'b1 || bus.dout !== 1'b0 || bus.stuff_err !== 1'b0 ||
                   bus.stuff_drop !== 1'b0 || bus.bit_cnt !== 8'd0)
      $display("FAIL end_pass got v=%b d=%b err=%b drop=%b cnt=%0d want 1 0 0 0 0",
               bus.dout_valid, bus.dout, bus.stuff_err, bus.stuff_drop, bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.sample_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.dout !== 1'b1 || bus.dout_valid !== 1'b0 || bus.stuff_drop !== 1'b0 ||
                   bus.stuff_err !== 1'b0 || bus.bit_cnt !== 8'd0)
      $display("FAIL async_rst got d=%b v=%b drop=%b err=%b cnt=%0d want 1 0 0 0 0",
               bus.dout, bus.dout_valid, bus.stuff_drop, bus.stuff_err, bus.bit_cnt); else n_pass++;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, (i == 5), 1'b1, 1'b0);
      n_total++; if (bus.dout_valid !== (i < 5) || bus.stuff_drop !== (i == 5))
        $display("FAIL post_rst%0d got v=%b drop=%b want v=%b drop=%b",
                 i, bus.dout_valid, bus.stuff_drop, i < 5, i == 5); else n_pass++;
    end
    n_total++; if (bus.bit_cnt !== 8'd5) $display("FAIL post_rst_cnt got %0d want 5", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit se, rx, de, ec;
    rx = 1'b0; de = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      se = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 20) rx = ~rx;
      if ($urandom_range(0, 59) == 0) de = ~de;
      ec = ($urandom_range(0, 24) == 0);
      cycle(se, rx, de, ec);
      n_total++; if (bus.dout_valid !== e_valid || bus.stuff_drop !== e_drop ||
                     bus.stuff_err !== m_err || bus.bit_cnt !== m_cnt[CNT_W-1:0] ||
                     (e_valid && bus.dout !== m_dout))
        $display("FAIL rand%0d got v=%b drop=%b err=%b cnt=%0d d=%b want v=%b drop=%b err=%b cnt=%0d d=%b",
                 n, bus.dout_valid, bus.stuff_drop, bus.stuff_err, bus.bit_cnt, bus.dout,
                 e_valid, e_drop, m_err, m_cnt, m_dout); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stuff_removal();
    test_stuff_run();
    test_stuff_error();
    test_region_end();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
